// File: rtl/lift_pkg.sv
// Shared phase encoding, default sizing and chunk-count helpers for the S3-lift sequencer.
package lift_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_CLR   = 3'd1,
        PH_MUL   = 3'd2,
        PH_FOLD  = 3'd3,
        PH_SUB   = 3'd4,
        PH_NORM  = 3'd5,
        PH_DRAIN = 3'd6,
        PH_DONE  = 3'd7
    } lift_phase_t;

    localparam int DEF_N_COEF = 700;
    localparam int DEF_COEF_W = 13;
    localparam int DEF_LANES  = 7;

    function automatic int calc_nchunk(input int n_coef, input int lanes);
        return (n_coef + lanes - 1) / lanes;
    endfunction

    // A single chunk still needs a one-bit index port.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/lift_chunk_cnt.sv
// Wrapping chunk index counter; last flags the final chunk so the FSM can exit a phase.
module lift_chunk_cnt #(
    parameter int IDX_W = 7,
    parameter int LAST  = 99
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] count,
    output logic             last
);

    assign last = (count == IDX_W'(LAST));

    // NOTE: flop updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/lift_seq_ctrl.sv
// S3-lift sequencer: CLR, MUL, FOLD, SUB, NORM, DRAIN, DONE with per-chunk strobes.
// Define LIFT_SEQ_PERF_EN to add the cyc_cnt / stall_cnt performance counters.
module lift_seq_ctrl
    import lift_pkg::*;
#(
    parameter int N_COEF = DEF_N_COEF,
    parameter int COEF_W = DEF_COEF_W,
    parameter int LANES  = DEF_LANES,
    localparam int NCHUNK = calc_nchunk(N_COEF, LANES),
    localparam int IDX_W  = calc_idx_w(NCHUNK)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output lift_phase_t      phase,
    output logic [IDX_W-1:0] chunk_idx,
    output logic             dp_clr,
    input  logic             dp_ready,
    output logic             dp_step,
    output logic             out_valid,
    input  logic             out_ready
`ifdef LIFT_SEQ_PERF_EN
    ,
    output logic [31:0]      cyc_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    if (N_COEF < 1 || LANES < 1 || COEF_W < 1) begin : g_bad_cfg
        $error("lift_seq_ctrl: N_COEF, LANES and COEF_W must be positive");
    end

    lift_phase_t state, state_nxt;
    logic        stepping;
    logic        cnt_last;

    assign stepping = (state == PH_MUL) || (state == PH_SUB) || (state == PH_NORM);
    assign dp_step  = stepping & dp_ready;
    assign phase    = state;

    lift_chunk_cnt #(
        .IDX_W (IDX_W),
        .LAST  (NCHUNK - 1)
    ) u_chunk_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == PH_CLR),
        .inc   (dp_step | (out_valid & out_ready)),
        .count (chunk_idx),
        .last  (cnt_last)
    );

    // NOTE: state_nxt gets its default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            PH_IDLE:  if (start) state_nxt = PH_CLR;
            PH_CLR:   state_nxt = PH_MUL;
            PH_MUL:   if (dp_step && cnt_last) state_nxt = PH_FOLD;
            PH_FOLD:  state_nxt = PH_SUB;
            PH_SUB:   if (dp_step && cnt_last) state_nxt = PH_NORM;
            PH_NORM:  if (dp_step && cnt_last) state_nxt = PH_DRAIN;
            PH_DRAIN: if (out_ready && cnt_last) state_nxt = PH_DONE;
            PH_DONE:  state_nxt = PH_IDLE;
            default:  state_nxt = PH_IDLE;
        endcase
    end

    // Status outputs are decoded from state_nxt and registered so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PH_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            dp_clr    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != PH_IDLE);
            done      <= (state_nxt == PH_DONE);
            dp_clr    <= (state_nxt == PH_CLR);
            out_valid <= (state_nxt == PH_DRAIN);
        end
    end

`ifdef LIFT_SEQ_PERF_EN
    logic accept;
    logic stall_now;

    assign accept    = (state == PH_IDLE) & start;
    assign stall_now = (stepping & ~dp_ready) | (out_valid & ~out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
        end else if (accept) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (busy && (cyc_cnt != '1)) cyc_cnt <= cyc_cnt + 32'd1;
            if (stall_now && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lift_seq_ctrl.sv
// Directed bench for lift_seq_ctrl: a 3-chunk instance for sequencing/stall/reset cases, a default instance for latency.
`timescale 1ns/1ps
module tb_lift_seq_ctrl;
    import lift_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_start = 1'b0, s_dp_ready = 1'b1, s_out_ready = 1'b1;
    logic        s_busy, s_done, s_dp_clr, s_dp_step, s_out_valid;
    lift_phase_t s_phase;
    logic [1:0]  s_idx;

    logic        b_start = 1'b0, b_dp_ready = 1'b1, b_out_ready = 1'b1;
    logic        b_busy, b_done, b_dp_clr, b_dp_step, b_out_valid;
    lift_phase_t b_phase;
    logic [6:0]  b_idx;

`ifdef LIFT_SEQ_PERF_EN
    logic [31:0] s_cyc, s_stall, b_cyc, b_stall;
`endif

    lift_seq_ctrl #(.N_COEF(21), .COEF_W(13), .LANES(7)) u_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s_start),
        .busy      (s_busy),
        .done      (s_done),
        .phase     (s_phase),
        .chunk_idx (s_idx),
        .dp_clr    (s_dp_clr),
        .dp_ready  (s_dp_ready),
        .dp_step   (s_dp_step),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready)
`ifdef LIFT_SEQ_PERF_EN
        ,
        .cyc_cnt   (s_cyc),
        .stall_cnt (s_stall)
`endif
    );

    lift_seq_ctrl u_big (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (b_start),
        .busy      (b_busy),
        .done      (b_done),
        .phase     (b_phase),
        .chunk_idx (b_idx),
        .dp_clr    (b_dp_clr),
        .dp_ready  (b_dp_ready),
        .dp_step   (b_dp_step),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
`ifdef LIFT_SEQ_PERF_EN
        ,
        .cyc_cnt   (b_cyc),
        .stall_cnt (b_stall)
`endif
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one job on the small instance from IDLE; exp_ph/exp_idx hold the expected
    // phase and chunk_idx per cycle (cycle 1 = first cycle after the accepting edge).
    task automatic run_small(input string tag, input string exp_ph, input string exp_idx,
                             input int stall_from, input int stall_len, input logic [7:0] or_pat,
                             input int restart_a, input int restart_b, input int exp_steps);
        int len, n_step, n_hs, k_drain;
        len = exp_ph.len();
        n_step = 0;
        n_hs = 0;
        k_drain = 0;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int c = 1; c <= len + 2; c++) begin
            int eph, eidx;
            eph  = (c <= len) ? int'(exp_ph[c-1]) - 48 : 0;
            eidx = (c <= len) ? int'(exp_idx[c-1]) - 48 : 0;
            s_dp_ready  = !(c >= stall_from && c < stall_from + stall_len);
            s_out_ready = (eph == 6) ? or_pat[k_drain] : 1'b1;
            s_start     = (c == restart_a) || (c == restart_b);
            #1;
            check($sformatf("%s c%0d phase", tag, c), s_phase, eph);
            check($sformatf("%s c%0d idx", tag, c), s_idx, eidx);
            check($sformatf("%s c%0d busy", tag, c), s_busy, (c <= len));
            check($sformatf("%s c%0d done", tag, c), s_done, (c == len));
            check($sformatf("%s c%0d dp_clr", tag, c), s_dp_clr, (c == 1));
            check($sformatf("%s c%0d out_valid", tag, c), s_out_valid, (eph == 6));
            check($sformatf("%s c%0d dp_step", tag, c), s_dp_step,
                  ((eph == 2) || (eph == 4) || (eph == 5)) && s_dp_ready);
            if (s_dp_step) n_step++;
            if (s_out_valid && s_out_ready) n_hs++;
            if (eph == 6) k_drain++;
            step();
        end
        s_start = 1'b0;
        s_dp_ready = 1'b1;
        s_out_ready = 1'b1;
        check({tag, " step count"}, n_step, exp_steps);
        check({tag, " handshakes"}, n_hs, 3);
    endtask

    initial begin
        int bsteps, bhs, bdone_c, bdones;

        #12;
        check("reset s_phase", s_phase, 0);
        check("reset s_idx", s_idx, 0);
        check("reset s_busy", s_busy, 0);
        check("reset s_done", s_done, 0);
        check("reset s_dp_clr", s_dp_clr, 0);
        check("reset s_out_valid", s_out_valid, 0);
        check("reset s_dp_step", s_dp_step, 0);
        check("reset b_phase", b_phase, 0);
        check("reset b_busy", b_busy, 0);
`ifdef LIFT_SEQ_PERF_EN
        check("reset s_cyc", s_cyc, 0);
        check("reset s_stall", s_stall, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle after reset", s_phase, 0);

        run_small("basic", "122234445556667", "001200120120120", 0, 0, 8'hFF, 0, 0, 9);
`ifdef LIFT_SEQ_PERF_EN
        check("basic cyc_cnt", s_cyc, 15);
        check("basic stall_cnt", s_stall, 0);
`endif

        run_small("dpstall", "1222344444445556667", "0012001111120120120", 7, 4, 8'hFF, 0, 0, 9);
`ifdef LIFT_SEQ_PERF_EN
        check("dpstall cyc_cnt", s_cyc, 19);
        check("dpstall stall_cnt", s_stall, 4);
`endif

        run_small("drain", "12223444555666667", "00120012012001120", 0, 0, 8'hFA, 0, 0, 9);
`ifdef LIFT_SEQ_PERF_EN
        check("drain cyc_cnt", s_cyc, 17);
        check("drain stall_cnt", s_stall, 2);
`endif

        run_small("restart", "122234445556667", "001200120120120", 0, 0, 8'hFF, 3, 15, 9);
`ifdef LIFT_SEQ_PERF_EN
        check("restart cyc_cnt", s_cyc, 15);
`endif

        // Reset asserted mid-NORM must clear everything without waiting for a clock edge.
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int c = 1; c < 11; c++) step();
        check("pre-reset phase", s_phase, 5);
        check("pre-reset idx", s_idx, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst phase", s_phase, 0);
        check("async rst idx", s_idx, 0);
        check("async rst busy", s_busy, 0);
        check("async rst done", s_done, 0);
        check("async rst dp_clr", s_dp_clr, 0);
        check("async rst out_valid", s_out_valid, 0);
        check("async rst dp_step", s_dp_step, 0);
`ifdef LIFT_SEQ_PERF_EN
        check("async rst cyc_cnt", s_cyc, 0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("post-rst idle done c%0d", c), s_done, 0);
            check($sformatf("post-rst idle phase c%0d", c), s_phase, 0);
        end
        run_small("post_rst", "122234445556667", "001200120120120", 0, 0, 8'hFF, 0, 0, 9);

        // Default configuration latency.
        bsteps = 0;
        bhs = 0;
        bdone_c = -1;
        bdones = 0;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        for (int c = 1; c <= 420; c++) begin
            if (c == 101) begin
                check("big last MUL phase", b_phase, 2);
                check("big last MUL idx", b_idx, 99);
            end
            if (c == 102) begin
                check("big FOLD phase", b_phase, 3);
                check("big FOLD idx", b_idx, 0);
            end
            if (b_dp_step) bsteps++;
            if (b_out_valid && b_out_ready) bhs++;
            if (b_done) begin
                bdones++;
                bdone_c = c;
            end
            step();
        end
        check("big done cycle", bdone_c, 403);
        check("big done pulses", bdones, 1);
        check("big dp_step count", bsteps, 300);
        check("big handshakes", bhs, 100);
        check("big final phase", b_phase, 0);
        check("big final busy", b_busy, 0);
`ifdef LIFT_SEQ_PERF_EN
        check("big cyc_cnt", b_cyc, 403);
        check("big stall_cnt", b_stall, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
